// File: rtl/tdm_demux161_pkg.sv
// Shared definitions for the 16:1 TDM link: slot geometry, receiver
// state encoding and the output bit-order helper.
package tdm_demux161_pkg;

   localparam int NUM_SLOTS = 16;
   localparam int SEL_W     = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } state_e;

   // Mirror a word so that slot k lands in bit NUM_SLOTS-1-k.
   function automatic logic [NUM_SLOTS-1:0] bit_reverse(input logic [NUM_SLOTS-1:0] w);
      logic [NUM_SLOTS-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         r[i] = w[NUM_SLOTS-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/tdm_demux161_dec416_df.sv
// 4-to-16 one-hot decoder built as two 2-to-4 stages, mirroring the 4:1
// tree of the transmit mux. The upper stage carries the write gate.
module dec416_df
   import tdm_demux161_pkg::*;
(
   input  logic [SEL_W-1:0]     sel,
   input  logic                 wr_en,
   output logic [NUM_SLOTS-1:0] we
);

   logic [3:0] hi;
   logic [3:0] lo;

   // Decode each half of sel, then AND the two one-hot vectors.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
      hi = '0;
      lo = '0;
      we = '0;
      hi[sel[3:2]] = wr_en;
      lo[sel[1:0]] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            we[4*i+j] = hi[i] & lo[j];
         end
      end
   end

endmodule

// File: rtl/tdm_demux161.sv
// Receive end of the 16:1 TDM link: collects one bit per enabled cycle into
// a shadow word and publishes the completed word with a one-cycle strobe.
module tdm_demux161
   import tdm_demux161_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din,
   input  logic                 en,
   input  logic                 sync,
   output logic [NUM_SLOTS-1:0] y,
   output logic                 valid,
   output logic [SEL_W-1:0]     sel,
   output logic                 frame_err
);

   localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_SLOTS - 1);

   state_e               state_q, state_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [NUM_SLOTS-1:0] shadow_q, shadow_d;
   logic [NUM_SLOTS-1:0] y_q, y_d;
   logic                 valid_q, valid_d;
   logic                 frame_err_q, frame_err_d;

   logic [SEL_W-1:0]     wr_sel;
   logic                 wr_en;
   logic [NUM_SLOTS-1:0] we;
   logic [NUM_SLOTS-1:0] merged;

   // A sync always addresses slot 0; otherwise only RECV accepts bits.
   assign wr_sel = sync ? '0 : sel_q;
   assign wr_en  = en & (sync | (state_q == ST_RECV));

   dec416_df u_dec (
      .sel   (wr_sel),
      .wr_en (wr_en),
      .we    (we)
   );

   // Shadow with the incoming bit merged into the addressed slot only.
   assign merged = (shadow_q & ~we) | (we & {NUM_SLOTS{din}});

   // Next-state, counter and register-input logic for the receive FSM.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      shadow_d    = shadow_q;
      y_d         = y_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      if (en) begin
         unique case (state_q)
            ST_IDLE: begin
               if (sync) begin
                  shadow_d = merged;
                  sel_d    = SEL_W'(1);
                  state_d  = ST_RECV;
               end
            end
            ST_RECV: begin
               if (sync) begin
                  // Early sync: drop the partial frame, restart at slot 0.
                  frame_err_d = 1'b1;
                  shadow_d    = we & {NUM_SLOTS{din}};
                  sel_d       = SEL_W'(1);
               end else if (sel_q == LAST_SLOT) begin
                  shadow_d = merged;
                  y_d      = LSB_FIRST ? merged : bit_reverse(merged);
                  valid_d  = 1'b1;
                  sel_d    = '0;
                  state_d  = ST_IDLE;
               end else begin
                  shadow_d = merged;
                  sel_d    = sel_q + SEL_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q     <= ST_IDLE;
         sel_q       <= '0;
         shadow_q    <= '0;
         y_q         <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         shadow_q    <= shadow_d;
         y_q         <= y_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign y         = y_q;
   assign valid     = valid_q;
   assign sel       = sel_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demux161.sv
// Bench for tdm_demux161: a vector table for the FSM corners plus frame
// sequences; completed words are checked through scoreboard queues.
module tb_tdm_demux161;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        din = 1'b0;
   logic        en = 1'b0;
   logic        sync = 1'b0;
   logic [15:0] y, y_m;
   logic        valid, valid_m;
   logic [3:0]  sel, sel_m;
   logic        frame_err, frame_err_m;

   int checks = 0;
   int failures = 0;
   int exp_valid = 0;
   int exp_err = 0;
   int valid_seen = 0;
   int err_seen = 0;
   int en_count = 0;
   int last_valid_en = 0;
   int prev_valid_en = 0;

   logic [15:0] sb_q[$];
   logic [15:0] sb_m_q[$];

   typedef struct {
      logic       en;
      logic       sync;
      logic       din;
      logic [3:0] exp_sel;
      logic       exp_err;
   } vec_t;

   vec_t vecs[8];

   tdm_demux161 #(.LSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
      .y(y), .valid(valid), .sel(sel), .frame_err(frame_err)
   );

   tdm_demux161 #(.LSB_FIRST(1'b0)) dut_m (
      .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
      .y(y_m), .valid(valid_m), .sel(sel_m), .frame_err(frame_err_m)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] rev16(input logic [15:0] w);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[15-i] = w[i];
      return r;
   endfunction

   // One clock with the given inputs; returns just after the edge.
   task automatic cycle(input logic e, input logic s, input logic d);
      en = e;
      sync = s;
      din = d;
      @(posedge clk);
      #1;
      if (e) en_count++;
   endtask

   task automatic send_frame(input logic [15:0] w, input int gap_a, input int gap_b,
                             input int gap_len, input logic abort_exp);
      for (int k = 0; k < 16; k++) begin
         if (k == 15) begin
            sb_q.push_back(w);
            sb_m_q.push_back(rev16(w));
            exp_valid++;
         end
         cycle(1'b1, k == 0, w[k]);
         check("sel_step", sel, (k + 1) % 16);
         if (k == 0) begin
            check("abort_err", frame_err, abort_exp);
            if (abort_exp) exp_err++;
         end
         if (k == gap_a || k == gap_b) begin
            for (int g = 0; g < gap_len; g++) begin
               cycle(1'b0, 1'b0, 1'b1);
               check("sel_gap_hold", sel, k + 1);
               check("gap_no_valid", valid, 0);
            end
         end
      end
      cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_partial(input logic [15:0] w, input int n);
      for (int k = 0; k < n; k++) cycle(1'b1, k == 0, w[k]);
   endtask

   task automatic check_totals(input string tag);
      check({tag, "_valid_cnt"}, valid_seen, exp_valid);
      check({tag, "_err_cnt"}, err_seen, exp_err);
      check({tag, "_sb_empty"}, sb_q.size() + sb_m_q.size(), 0);
   endtask

   // Scoreboard monitor: compare every published word against the queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (valid && frame_err) check("pulse_overlap", 1, 0);
         if (frame_err) err_seen++;
         if (valid) begin
            valid_seen++;
            prev_valid_en = last_valid_en;
            last_valid_en = en_count;
            if (sb_q.size() == 0) check("unexpected_valid", y, 16'hxxxx);
            else check("y_word", y, sb_q.pop_front());
         end
         if (valid_m) begin
            if (sb_m_q.size() == 0) check("unexpected_valid_m", y_m, 16'hxxxx);
            else check("y_word_msb", y_m, sb_m_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{1'b1, 1'b0, 1'b1, 4'd0, 1'b0};  // IDLE, no sync: discard
      vecs[1] = '{1'b0, 1'b1, 1'b1, 4'd0, 1'b0};  // sync without en ignored
      vecs[2] = '{1'b1, 1'b1, 1'b1, 4'd1, 1'b0};  // frame start
      vecs[3] = '{1'b1, 1'b0, 1'b0, 4'd2, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 4'd2, 1'b0};  // en low holds sel
      vecs[5] = '{1'b1, 1'b0, 1'b1, 4'd3, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 4'd1, 1'b1};  // early sync at sel=3
      vecs[7] = '{1'b1, 1'b0, 1'b0, 4'd2, 1'b0};  // error pulse gone

      // Reset state
      @(posedge clk);
      #1;
      check("rst_y", y, 16'h0000);
      check("rst_valid", valid, 0);
      check("rst_sel", sel, 0);
      check("rst_err", frame_err, 0);
      rst = 1'b0;

      // FSM corner vectors
      for (int i = 0; i < 8; i++) begin
         cycle(vecs[i].en, vecs[i].sync, vecs[i].din);
         check($sformatf("vec%0d_sel", i), sel, vecs[i].exp_sel);
         check($sformatf("vec%0d_err", i), frame_err, vecs[i].exp_err);
         check($sformatf("vec%0d_valid", i), valid, 0);
         if (vecs[i].exp_err) exp_err++;
      end
      check("vec_y_held", y, 16'h0000);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      check_totals("vec");

      // Clean frame
      send_frame(16'hA5C3, -1, -1, 0, 1'b0);
      check("clean_y", y, 16'hA5C3);
      check("clean_sel", sel, 0);
      check_totals("clean");

      // Same frame with en gaps after slots 4 and 11
      send_frame(16'hA5C3, 4, 11, 3, 1'b0);
      check("gap_y", y, 16'hA5C3);
      check_totals("gap");

      // Early sync at sel=9, then a full frame
      send_partial(16'hFFFF, 9);
      check("pre_abort_sel", sel, 9);
      send_frame(16'h0F0F, -1, -1, 0, 1'b1);
      check("abort_y", y, 16'h0F0F);
      check_totals("abort");

      // Back-to-back frames with no idle cycle between them
      for (int k = 0; k < 16; k++) begin
         if (k == 15) begin
            sb_q.push_back(16'h1234);
            sb_m_q.push_back(rev16(16'h1234));
            exp_valid++;
         end
         cycle(1'b1, k == 0, 1'(16'h1234 >> k));
      end
      send_frame(16'hFFFF, -1, -1, 0, 1'b0);
      check("b2b_spacing", last_valid_en - prev_valid_en, 16);
      check("b2b_y", y, 16'hFFFF);
      check_totals("b2b");

      // Reset mid-frame after a prior word
      send_frame(16'hBEEF, -1, -1, 0, 1'b0);
      send_partial(16'h0000, 7);
      check("pre_rst_sel", sel, 7);
      check("pre_rst_y", y, 16'hBEEF);
      rst = 1'b1;
      #2;
      check("midrst_y", y, 16'h0000);
      check("midrst_sel", sel, 0);
      check("midrst_valid", valid, 0);
      check("midrst_err", frame_err, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_frame(16'h8001, -1, -1, 0, 1'b0);
      check("post_rst_y", y, 16'h8001);
      check_totals("midrst");

      // Slot 0 only: MSB-first instance must show it in bit 15
      send_frame(16'h0001, -1, -1, 0, 1'b0);
      check("lsb_first_y", y, 16'h0001);
      check("msb_first_y", y_m, 16'h8000);
      check("msb_first_sel", sel_m, 0);
      check_totals("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
